demux_bank: RTL and testbench
=============================

# demux_bank

Parametrised, registered 1-to-N demultiplexer with a per-channel one-entry holding buffer and a valid/ready handshake on the input and on every output channel. It succeeds the fixed 1:8 gate-level demux, with three additions:
- configurable data width and channel count;
- an auto-incrementing scan mode;
- back-pressure from each destination.

It sits between a single producer and N independent consumers in the datapath.

## Interface
Parameters:
- DATA_W, 8, payload width in bits (1..32)
- N_OUT, 8, number of output channels; power of two, 2..64
- SEL_W, $clog2(N_OUT), derived localparam, not overridable

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mode  in  1  0 = addressed (channel from sel), 1 = scan (channel from scan_ptr)
- sel  in  SEL_W  target channel in addressed mode
- in_valid  in  1  producer has data
- in_data  in  DATA_W  payload
- in_ready  out  1  target channel can accept this cycle
- out_valid  out  N_OUT  bit k: channel k buffer holds unconsumed data
- out_data  out  N_OUT*DATA_W  channel k at [k*DATA_W +: DATA_W]
- out_ready  in  N_OUT  bit k: consumer k takes data this cycle
- scan_ptr  out  SEL_W  current scan-mode target channel

## Operation
- Target channel: t = mode ? scan_ptr : sel. Evaluated combinationally each cycle.
- in_ready = !out_valid[t] || out_ready[t]. This is combinational from mode, sel, scan_ptr, out_valid and out_ready.
- Accept: in_valid && in_ready at a rising edge.
  - data_reg[t] <= in_data
  - out_valid[t] <= 1
- Drain: out_valid[k] && out_ready[k] with no accept into k. Then out_valid[k] <= 0.
  - data_reg[k] keeps its last value, so out_data is stable when invalid.
- Drain and accept on the same channel in the same cycle:
  - out_valid[t] stays 1.
  - data_reg[t] takes the new in_data, so full throughput is kept.
- Channels other than t are only affected by their own out_ready.
- out_ready[k] while out_valid[k] = 0 is ignored.
- in_valid = 0: no state change other than drains.
- Scan pointer:
  - mode = 1 and accept: scan_ptr <= scan_ptr + 1 mod N_OUT, wrapping N_OUT-1 -> 0.
  - mode = 0: scan_ptr holds its value. sel never changes scan_ptr.
  - A stalled transfer (in_ready = 0) does not advance scan_ptr. Scan never skips a busy channel.
- Mode change takes effect in the same cycle through t. No flush occurs and buffered data is retained.
- Every sel value is legal because N_OUT is a power of two.

## Timing
- Reset (async assert; deasserted synchronously by the system):
  - out_valid = 0
  - all data_reg = 0, so out_data = 0
  - scan_ptr = 0
  - in_ready = 1
- Reset asserted mid-transfer discards all buffered data immediately, without waiting for a clock edge.
- Latency: data accepted at edge n appears on out_data and out_valid from edge n until it is drained. Input to output latency is 1 cycle.
- Throughput: one transfer per cycle, provided the target channel is empty or draining in the same cycle.
- out_valid, out_data and scan_ptr are registered outputs. in_ready is the only combinational output.
- No combinational path from in_valid or in_data to any output.

## Test plan
- Reset then addressed writes. Apply rst=1 then release; with mode=0, sel=5, in_data=0xA5, in_valid=1, out_ready=0 -> after the edge out_valid=0x20, channel 5 data=0xA5, all other channels 0, scan_ptr=0.
- Back-pressure. Channel 5 is full and out_ready[5]=0; present sel=5, in_data=0x3C -> in_ready=0 and the data is unchanged. Raise out_ready[5] -> in_ready=1; on the next edge channel 5 data=0x3C and out_valid[5] stays 1.
- Scan wrap with N_OUT=8. Set mode=1 and out_ready=0xFF, then send 10 words 0x01..0x0A -> channels 0..7 receive 0x01..0x08, then channel 0=0x09 and channel 1=0x0A; scan_ptr ends at 2.
- Scan stall. Set mode=1 with scan_ptr=3, out_valid[3]=1 and out_ready[3]=0; hold in_valid=1 for 4 cycles -> in_ready=0 and scan_ptr=3 throughout. Release out_ready[3] -> one accept into channel 3, then scan_ptr=4.
- Mode switch and independent drain. Fill channels 0 and 7 in mode 0, switch to mode=1, and pulse out_ready[7] only -> out_valid=0x01, channel 7 data still holds its last value, and scan_ptr is unchanged.
- Async reset mid-stream. Assert rst between clock edges during scan traffic -> out_valid=0, out_data=0, scan_ptr=0 and in_ready=1 immediately, before the next clk edge.

Source files
------------

// File: rtl/demux_bank.sv
// Registered 1-to-N demultiplexer with a one-entry holding buffer per output channel.
// The target channel comes from sel (addressed mode) or from an auto-incrementing scan pointer.
module demux_bank #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 8,
  localparam int SEL_W = $clog2(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  output logic [N_OUT-1:0]        out_valid,
  output logic [N_OUT*DATA_W-1:0] out_data,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [SEL_W-1:0]        scan_ptr
);

  // Handshake: a word moves on any rising edge where valid && ready are both high.
  // The producer side uses in_valid/in_ready; each consumer k uses out_valid[k]/out_ready[k].
  // A full channel that is draining in the same cycle still accepts, so throughput is one word per cycle.

  logic [SEL_W-1:0]  tgt;
  logic              accept;
  logic [DATA_W-1:0] data_reg [N_OUT];

  assign tgt      = mode ? scan_ptr : sel;
  assign in_ready = !out_valid[tgt] || out_ready[tgt];
  assign accept   = in_valid && in_ready;

  for (genvar k = 0; k < N_OUT; k++) begin : g_chan
    logic hit;
    assign hit = accept && (tgt == SEL_W'(k));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_valid[k] <= 1'b0;
        data_reg[k]  <= '0;
      end else if (hit) begin
        out_valid[k] <= 1'b1;
        data_reg[k]  <= in_data;
      end else if (out_ready[k]) begin
        // Data is kept after a drain so out_data stays stable while invalid.
        out_valid[k] <= 1'b0;
      end
    end

    assign out_data[k*DATA_W +: DATA_W] = data_reg[k];
  end

  // Scan never skips a busy channel: the pointer moves only on an accepted word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_ptr <= '0;
    end else if (mode && accept) begin
      scan_ptr <= scan_ptr + SEL_W'(1);
    end
  end

endmodule

// File: tb/tb_demux_bank.sv
// Self-checking bench for demux_bank (DATA_W=8, N_OUT=8): directed scenarios plus random traffic,
// with a reference model of channel state and a scoreboard of accepted words checked at drain time.
module tb_demux_bank;
  localparam int DATA_W = 8;
  localparam int N_OUT  = 8;
  localparam int SEL_W  = 3;
  localparam int W      = SEL_W + DATA_W;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic [DATA_W-1:0]       in_data;
  logic                    in_ready;
  logic [N_OUT-1:0]        out_valid;
  logic [N_OUT*DATA_W-1:0] out_data;
  logic [N_OUT-1:0]        out_ready;
  logic [SEL_W-1:0]        scan_ptr;

  always #5 clk = ~clk;

  demux_bank #(.DATA_W(DATA_W), .N_OUT(N_OUT)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .scan_ptr(scan_ptr)
  );

  // Reference state and scoreboard of {channel, data} words accepted but not yet drained.
  logic [N_OUT-1:0]  m_valid;
  logic [DATA_W-1:0] m_data [N_OUT];
  logic [SEL_W-1:0]  m_ptr;
  logic [W-1:0]      exp_q [$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] chan(input int k);
    return out_data[k*DATA_W +: DATA_W];
  endfunction

  task automatic model_reset();
    m_valid = '0;
    m_ptr   = '0;
    for (int k = 0; k < N_OUT; k++) m_data[k] = '0;
    exp_q.delete();
  endtask

  task automatic check_state();
    check("out_valid", out_valid, m_valid);
    check("scan_ptr", scan_ptr, m_ptr);
    for (int k = 0; k < N_OUT; k++) check($sformatf("data_ch%0d", k), chan(k), m_data[k]);
  endtask

  // Called just after a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    logic [SEL_W-1:0] t;
    logic             rdy;
    logic             acc;
    logic [W-1:0]     e;
    bit               found;
    t   = mode ? m_ptr : sel;
    rdy = !m_valid[t] || out_ready[t];
    acc = in_valid && rdy;
    #1;
    check("in_ready", in_ready, rdy);
    for (int k = 0; k < N_OUT; k++) begin
      if (m_valid[k] && out_ready[k]) begin
        found = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
          e = exp_q[i];
          if (!found && e[W-1:DATA_W] == SEL_W'(k)) begin
            check($sformatf("drain_ch%0d", k), chan(k), e[DATA_W-1:0]);
            exp_q.delete(i);
            found = 1'b1;
          end
        end
        if (!found) check($sformatf("sb_missing_ch%0d", k), 0, 1);
      end
    end
    if (acc) exp_q.push_back({t, in_data});
    @(posedge clk);
    for (int k = 0; k < N_OUT; k++) if (m_valid[k] && out_ready[k]) m_valid[k] = 1'b0;
    if (acc) begin
      m_valid[t] = 1'b1;
      m_data[t]  = in_data;
      if (mode) m_ptr = m_ptr + 3'd1;
    end
    @(negedge clk);
    check_state();
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; sel = '0; in_valid = 1'b0; in_data = '0; out_ready = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_state();
    check("reset_in_ready", in_ready, 1);
    rst = 1'b0;

    // Reset then addressed write.
    sel = 3'd5; in_data = 8'hA5; in_valid = 1'b1;
    step();
    check("t1_out_valid", out_valid, 8'h20);
    check("t1_ch5", chan(5), 8'hA5);
    check("t1_scan_ptr", scan_ptr, 0);

    // Back-pressure on a full channel.
    in_data = 8'h3C;
    step();
    check("t2_stall_ready", in_ready, 0);
    check("t2_stall_ch5", chan(5), 8'hA5);
    out_ready = 8'h20;
    #1 check("t2_release_ready", in_ready, 1);
    step();
    check("t2_ch5", chan(5), 8'h3C);
    check("t2_valid5", out_valid[5], 1);
    in_valid = 1'b0; out_ready = 8'hFF;
    step();
    out_ready = '0;

    // Scan wrap across all eight channels.
    mode = 1'b1; out_ready = 8'hFF; in_valid = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_data = 8'(i);
      step();
    end
    check("t3_scan_ptr", scan_ptr, 2);
    check("t3_ch0", chan(0), 8'h09);
    check("t3_ch1", chan(1), 8'h0A);
    check("t3_ch7", chan(7), 8'h08);
    in_valid = 1'b0;
    step();
    out_ready = '0;

    // Scan stall on a busy channel.
    mode = 1'b0; sel = 3'd3; in_data = 8'h33; in_valid = 1'b1;
    step();
    mode = 1'b1; in_data = 8'h22;
    step();
    in_data = 8'h44;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t4_stall_ptr", scan_ptr, 3);
      check("t4_stall_ready", in_ready, 0);
    end
    out_ready = 8'h08;
    step();
    check("t4_ptr_after", scan_ptr, 4);
    check("t4_ch3", chan(3), 8'h44);
    in_valid = 1'b0; out_ready = 8'hFF;
    step();
    out_ready = '0;

    // Mode switch and independent drain.
    mode = 1'b0; in_valid = 1'b1; sel = 3'd0; in_data = 8'h10;
    step();
    sel = 3'd7; in_data = 8'h70;
    step();
    in_valid = 1'b0; mode = 1'b1; out_ready = 8'h80;
    step();
    out_ready = '0;
    check("t5_out_valid", out_valid, 8'h01);
    check("t5_ch7", chan(7), 8'h70);
    check("t5_scan_ptr", scan_ptr, 4);

    // Random traffic in both modes.
    for (int i = 0; i < 60; i++) begin
      mode      = (i >= 30);
      sel       = SEL_W'($urandom_range(0, N_OUT - 1));
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = DATA_W'($urandom_range(0, 255));
      out_ready = N_OUT'($urandom_range(0, 255));
      step();
    end

    // Asynchronous reset between clock edges during scan traffic.
    #2 rst = 1'b1;
    #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_out_data", out_data, 0);
    check("t6_scan_ptr", scan_ptr, 0);
    check("t6_in_ready", in_ready, 1);
    model_reset();
    in_valid = 1'b0; out_ready = '0;
    @(negedge clk);
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
